if_fetch_queue: RTL and testbench

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/if_fetch_queue.sv | 131 +++++++++++++
 tb/tb_if_fetch_queue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch prefetch queue: issues sequential imem reads, buffers the
// responses in program order, and turns out-of-text fetches into AdEL entries.
module if_fetch_queue #(
   parameter int unsigned DEPTH      = 4,
   parameter logic [31:0] TEXT_START = 32'h0000_3000,
   parameter logic [31:0] TEXT_END   = 32'h0000_7000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     imem_req,
   output logic [31:0]              imem_addr,
   input  logic [31:0]              imem_rdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_code,
   output logic [31:0]              out_pc,
   output logic [4:0]               out_exc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [4:0]  EXC_ADEL = 5'd4;

   typedef struct packed {
      logic [31:0] code;
      logic [31:0] pc;
      logic [4:0]  exc;
   } entry_t;

   logic [31:0]   pc;
   logic [31:0]   inflight_pc;
   logic          inflight;
   logic          stop;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   entry_t        mem [DEPTH];

   logic          legal;
   logic          space;
   logic          fetch_exc;
   logic          resp_push;
   logic          push;
   logic          pop;
   logic [31:0]   rdata_clean;
   entry_t        push_entry;
   entry_t        head;

   // Fetch decision and queue handshakes.
   always_comb begin
      legal     = (pc >= TEXT_START) && (pc < TEXT_END) && (pc[1:0] == 2'b00);
      space     = (count + CW'(inflight)) < CW'(DEPTH);
      imem_req  = reset && legal && !stop && !redirect && space;
      // Exception entry waits for any outstanding response so only one push per cycle.
      fetch_exc = reset && !legal && !stop && !redirect && space && !inflight;
      resp_push = inflight && !redirect;
      push      = resp_push || fetch_exc;
      pop       = out_valid && out_ready && !redirect;
      imem_addr = pc;
   end

   // Unknown read data bits become zero.
   always_comb begin
      rdata_clean = '0;
      for (int i = 0; i < 32; i++) begin
         rdata_clean[i] = (imem_rdata[i] === 1'b1);
      end
   end

   always_comb begin
      push_entry = '0;
      if (resp_push) begin
         push_entry = '{code: rdata_clean, pc: inflight_pc, exc: 5'd0};
      end else begin
         push_entry = '{code: 32'h0, pc: pc, exc: EXC_ADEL};
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc          <= TEXT_START;
         inflight_pc <= '0;
         inflight    <= 1'b0;
         stop        <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
      end else if (redirect) begin
         pc          <= redirect_pc;
         inflight    <= 1'b0;
         stop        <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
      end else begin
         if (imem_req) begin
            pc <= pc + 32'd4;
         end
         inflight    <= imem_req;
         inflight_pc <= pc;
         if (fetch_exc) begin
            stop <= 1'b1;
         end
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Head entry, forced to zero when the queue is empty.
   always_comb begin
      head      = mem[rd_ptr];
      out_valid = (count != '0);
      out_code  = out_valid ? head.code : 32'h0;
      out_pc    = out_valid ? head.pc   : 32'h0;
      out_exc   = out_valid ? head.exc  : 5'd0;
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: expected entries are queued per scenario
// and consumed by a monitor at every accepted pop.
module tb_if_fetch_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          reset;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          imem_req;
   logic [31:0]   imem_addr;
   logic [31:0]   imem_rdata;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_code;
   logic [31:0]   out_pc;
   logic [4:0]    out_exc;
   logic [CW-1:0] count;

   logic [68:0] sbq[$];
   logic [68:0] exp_e;
   int n_checks = 0;
   int n_fail   = 0;
   int n_pops   = 0;

   if_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
      .out_pc(out_pc), .out_exc(out_exc), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: word value equals its address, one-cycle read.
   always @(posedge clk) begin
      imem_rdata <= imem_req ? imem_addr : 32'hDEAD_BEEF;
   end

   function automatic logic [68:0] ent(input logic [31:0] code, input logic [31:0] pc,
                                       input logic [4:0] exc);
      return {code, pc, exc};
   endfunction

   task automatic sb_stream(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) sbq.push_back(ent(start + 32'(4 * i), start + 32'(4 * i), 5'd0));
   endtask

   // Pop monitor and occupancy bound.
   always @(negedge clk) begin
      if (reset && out_valid && out_ready && !redirect) begin
         n_checks++;
         n_pops++;
         if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected got pc=%h code=%h exc=%0d", out_pc, out_code, out_exc);
         end else begin
            exp_e = sbq.pop_front();
            if ({out_code, out_pc, out_exc} !== exp_e) begin
               n_fail++;
               $display("FAIL pop_data got code=%h pc=%h exc=%0d exp code=%h pc=%h exc=%0d",
                        out_code, out_pc, out_exc, exp_e[68:37], exp_e[36:5], exp_e[4:0]);
            end
         end
      end
      n_checks++;
      if (count > CW'(DEPTH)) begin
         n_fail++;
         $display("FAIL overflow got count=%0d exp <= %0d", count, DEPTH);
      end
   end

   task automatic test_reset;
      #3;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
      n_checks++; if (count !== '0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", count); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", imem_req); end
      n_checks++; if (imem_addr !== 32'h3000) begin n_fail++; $display("FAIL rst_addr got=%h exp=3000", imem_addr); end
      n_checks++; if ({out_code, out_pc, out_exc} !== 69'h0) begin n_fail++; $display("FAIL rst_outs got pc=%h code=%h exc=%0d exp zero", out_pc, out_code, out_exc); end
   endtask

   task automatic test_stream;
      reset = 1'b0; #1;
      sbq.delete(); sb_stream(32'h3000, 40); n_pops = 0; out_ready = 1'b1;
      @(negedge clk); reset = 1'b1; #1;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin n_fail++; $display("FAIL str_first_req got req=%b addr=%h exp req=1 addr=3000", imem_req, imem_addr); end
      @(posedge clk); #1; @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL str_latency got valid=%b exp=0 in cycle 1", out_valid); end
      for (int c = 2; c <= 12; c++) begin
         @(posedge clk); #1; @(negedge clk);
         if (c == 2) begin
            n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3000) begin n_fail++; $display("FAIL str_cycle2 got valid=%b pc=%h exp valid=1 pc=3000", out_valid, out_pc); end
         end
      end
      @(posedge clk); #1; out_ready = 1'b0; @(negedge clk);
      n_checks++; if (n_pops !== 11) begin n_fail++; $display("FAIL str_throughput got pops=%0d exp=11", n_pops); end
      sbq.delete();
   endtask

   task automatic test_backpressure;
      reset = 1'b0; #1;
      out_ready = 1'b0; sbq.delete(); n_pops = 0;
      @(negedge clk); reset = 1'b1;
      repeat (10) begin @(posedge clk); #1; end
      @(negedge clk);
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL bp_count got=%0d exp=4", count); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req got=%b exp=0", imem_req); end
      n_checks++; if (imem_addr !== 32'h3010) begin n_fail++; $display("FAIL bp_pc got=%h exp=3010", imem_addr); end
      sb_stream(32'h3000, 20);
      @(posedge clk); #1; out_ready = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      out_ready = 1'b0; @(negedge clk);
      n_checks++; if (n_pops !== 5) begin n_fail++; $display("FAIL bp_pops got=%0d exp=5", n_pops); end
      sbq.delete();
   endtask

   task automatic test_redirect;
      reset = 1'b0; #1;
      out_ready = 1'b0; sbq.delete(); n_pops = 0;
      @(negedge clk); reset = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      redirect = 1'b1; redirect_pc = 32'h4180;
      @(negedge clk);
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL rd_pre_count got=%0d exp=3", count); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rd_req_in_redirect got=%b exp=0", imem_req); end
      @(posedge clk); #1;
      redirect = 1'b0; out_ready = 1'b1; sb_stream(32'h4180, 20); n_pops = 0;
      @(negedge clk);
      n_checks++; if (count !== '0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rd_flush got count=%0d valid=%b exp 0/0", count, out_valid); end
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4180) begin n_fail++; $display("FAIL rd_restart got req=%b addr=%h exp 1/4180", imem_req, imem_addr); end
      @(posedge clk); #1; @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rd_latency got valid=%b exp=0", out_valid); end
      for (int c = 7; c <= 12; c++) begin
         @(posedge clk); #1; @(negedge clk);
         if (c == 7) begin
            n_checks++; if (out_pc !== 32'h4180) begin n_fail++; $display("FAIL rd_first_pc got=%h exp=4180", out_pc); end
         end
      end
      @(posedge clk); #1; out_ready = 1'b0; @(negedge clk);
      n_checks++; if (n_pops !== 6) begin n_fail++; $display("FAIL rd_pops got=%0d exp=6", n_pops); end
      sbq.delete();
   endtask

   task automatic test_illegal(input logic [31:0] addr);
      out_ready = 1'b0;
      @(posedge clk); #1; redirect = 1'b1; redirect_pc = addr; sbq.delete(); n_pops = 0;
      @(posedge clk); #1; redirect = 1'b0;
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b0 || count !== '0) begin n_fail++; $display("FAIL ill_c1 addr=%h got req=%b count=%0d exp 0/0", addr, imem_req, count); end
      @(posedge clk); #1; @(negedge clk);
      n_checks++; if (count !== 3'd1 || out_pc !== addr || out_code !== 32'h0 || out_exc !== 5'd4)
         begin n_fail++; $display("FAIL ill_entry got count=%0d pc=%h code=%h exc=%0d exp 1/%h/0/4", count, out_pc, out_code, out_exc, addr); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1; @(negedge clk);
         n_checks++; if (imem_req !== 1'b0 || count !== 3'd1) begin n_fail++; $display("FAIL ill_stop got req=%b count=%0d exp 0/1", imem_req, count); end
      end
      sbq.push_back(ent(32'h0, addr, 5'd4));
      @(posedge clk); #1; out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      n_checks++; if (n_pops !== 1 || count !== '0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ill_drain got pops=%0d count=%0d valid=%b exp 1/0/0", n_pops, count, out_valid); end
   endtask

   task automatic test_end_of_text;
      sbq.delete(); n_pops = 0;
      sbq.push_back(ent(32'h6FF8, 32'h6FF8, 5'd0));
      sbq.push_back(ent(32'h6FFC, 32'h6FFC, 5'd0));
      sbq.push_back(ent(32'h0, 32'h7000, 5'd4));
      @(posedge clk); #1; redirect = 1'b1; redirect_pc = 32'h6FF8; out_ready = 1'b1;
      @(posedge clk); #1; redirect = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      @(negedge clk);
      n_checks++; if (n_pops !== 3 || sbq.size() != 0) begin n_fail++; $display("FAIL eot_pops got=%0d left=%0d exp 3/0", n_pops, sbq.size()); end
      n_checks++; if (count !== '0 || imem_req !== 1'b0 || imem_addr !== 32'h7000) begin n_fail++; $display("FAIL eot_stop got count=%0d req=%b addr=%h exp 0/0/7000", count, imem_req, imem_addr); end
      @(posedge clk); #1; out_ready = 1'b0;
   endtask

   task automatic test_async_reset;
      reset = 1'b0; #1;
      out_ready = 1'b0; sbq.delete(); n_pops = 0;
      @(negedge clk); reset = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      @(negedge clk);
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL ar_pre_count got=%0d exp=3", count); end
      #2; reset = 1'b0; #1;
      n_checks++; if (out_valid !== 1'b0 || count !== '0 || imem_req !== 1'b0 || out_pc !== 32'h0)
         begin n_fail++; $display("FAIL ar_immediate got valid=%b count=%0d req=%b pc=%h exp 0/0/0/0", out_valid, count, imem_req, out_pc); end
      repeat (2) begin @(posedge clk); #1; end
      n_checks++; if (count !== '0 || imem_addr !== 32'h3000) begin n_fail++; $display("FAIL ar_hold got count=%0d addr=%h exp 0/3000", count, imem_addr); end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
      #1 reset = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_illegal(32'h3002);
      test_illegal(32'h8000);
      test_end_of_text();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
